ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Four-master AHB arbiter. Produces the one-hot grant1..grant4 vector that drives the master-side address/control/write-data multiplexer.
- Sequences bus ownership using round-robin priority. Never re-arbitrates in the middle of a fixed-length burst or a locked sequence.
- Also drives hmaster and hmastlock for the slave side and decoder.
- Sits between the four master interfaces and the master multiplexer in the AHB interconnect.

Parameters:
- DEFAULT_MASTER, 1: master (1..4) granted out of reset and when no master requests.
- NUM_MASTERS, 4: fixed at 4. Present for documentation only; other values are unsupported.

Ports:
- hclk  in  1  bus clock; all state updates on the rising edge.
- hreset  in  1  synchronous, active-high reset.
- hbusreq1..hbusreq4  in  1 each  bus request from master n.
- hlock1..hlock4  in  1 each  locked-access request from master n.
- hready  in  1  transfer-complete from the selected slave (multiplexed).
- htrans  in  2  transfer type of the currently granted master (multiplexed).
- hburst  in  3  burst type of the currently granted master (multiplexed).
- grant1..grant4  out  1 each  registered, always exactly one-hot.
- hmaster  out  2  index of the granted master minus 1 (master1=0 .. master4=3).
- hmastlock  out  1  current transfer is part of a locked sequence.

Behaviour:
- Reset (hreset=1 at a clock edge):
  - grant = one-hot of DEFAULT_MASTER; hmaster = DEFAULT_MASTER-1; hmastlock = 0.
  - State = ARB; beat counter = 0; round-robin pointer = DEFAULT_MASTER.
  - Reset asserted mid-burst or mid-lock aborts immediately to these values.
- htrans encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- Beat accepted: hready=1 and htrans is NONSEQ or SEQ.
- Burst length L from hburst: 010/011 -> 4; 100/101 -> 8; 110/111 -> 16; 000 (SINGLE) and 001 (INCR) -> treated as 1.
- State machine (3 states):
  - ARB: re-arbitration allowed on every cycle with hready=1.
    - If the owner's hlock=1 and hbusreq=1 -> LOCKED; grant is retained.
    - Else if a NONSEQ is accepted with L>1 -> BURST; counter loaded with L-1; grant is retained.
  - BURST: counter decrements on each accepted SEQ. BUSY and hready=0 hold the counter.
    - When the accepted SEQ takes the counter from 1 to 0 -> ARB, with arbitration performed in that same cycle.
    - An accepted NONSEQ or IDLE (early termination) -> ARB immediately.
  - LOCKED: grant is held regardless of other requests.
    - Exit to ARB on a cycle with hready=1 and the owner's hlock=0.
    - An owner hbusreq=0 while in LOCKED has no effect until hlock drops.
- Arbitration (only when allowed and hready=1):
  - Round-robin search starts at pointer+1, wraps 4->1, and ends with the current owner (lowest priority).
  - First requester found wins; the pointer updates to the winner.
  - If no hbusreq is asserted, the grant goes to DEFAULT_MASTER.
- Latency: the new grant, hmaster and hmastlock are registered and visible the cycle after the arbitration edge.
- Stall: hready=0 freezes grant, state, counter and pointer.
- hmastlock: 1 while in LOCKED, and in the cycle LOCKED is entered; 0 otherwise.
- Simultaneous events:
  - Lock request and burst start in the same cycle -> LOCKED takes precedence; the burst is not counted.
  - The requests of all four masters are resolved by the rotation order alone.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: the round-robin search is replaced by fixed priority master1 > master2 > master3 > master4. The pointer is unused. BURST/LOCKED hold rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, then all hbusreq=0, hready=1 for 5 cycles -> grant1=1 (DEFAULT_MASTER=1), hmaster=0, hmastlock=0 throughout.
- hbusreq1..4 all held high, single transfers (NONSEQ, hburst=000), hready=1 -> grant rotates 2,3,4,1,2 on consecutive cycles.
- Master 2 granted; NONSEQ with hburst=011 (INCR4), then 3 SEQ, with hbusreq3=1 and hready low for 2 cycles mid-burst -> grant2 held for 4 accepted beats plus stalls; grant3 appears the cycle after the last SEQ is accepted.
- Master 3 asserts hlock3 and hbusreq3 with all others requesting; 6 transfers, then hlock3=0 -> hmastlock=1 and grant3 held for all 6; re-arbitration occurs on the first hready=1 cycle with hlock3=0.
- hreset asserted mid-INCR8 on master 4 (counter=5) -> next cycle grant1=1, state ARB, hmastlock=0.
- With ARB_FIXED_PRIORITY_EN, hbusreq2 and hbusreq4 high continuously -> grant2 each arbitration; master 4 is never granted.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: four-master AHB arbiter, round-robin with burst/lock hold (ARB_FIXED_PRIORITY_EN selects fixed priority 1>2>3>4)
module ahb_bus_arbiter #(
    parameter int DEFAULT_MASTER = 1,
    parameter int NUM_MASTERS    = 4
) (
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hbusreq1,
    input  logic       hbusreq2,
    input  logic       hbusreq3,
    input  logic       hbusreq4,
    input  logic       hlock1,
    input  logic       hlock2,
    input  logic       hlock3,
    input  logic       hlock4,
    input  logic       hready,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    output logic       grant1,
    output logic       grant2,
    output logic       grant3,
    output logic       grant4,
    output logic [1:0] hmaster,
    output logic       hmastlock
);
    localparam logic [1:0] DEF = 2'(DEFAULT_MASTER - 1);
    typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d, blen_m1;
    logic [1:0] ptr_q, ptr_d, hmaster_q, hmaster_d, win;
    logic [NUM_MASTERS-1:0] req, lck, grant_q, grant_d;
    logic hmastlock_q, hmastlock_d, arb, beat, nonseq, seq, idle;
    assign req = {hbusreq4, hbusreq3, hbusreq2, hbusreq1};
    assign lck = {hlock4, hlock3, hlock2, hlock1};
    assign beat = hready & htrans[1];
    assign nonseq = htrans == 2'b10;
    assign seq = htrans == 2'b11;
    assign idle = htrans == 2'b00;
    assign blen_m1 = hburst inside {[3'd2:3'd3]} ? 4'd3 :
                     hburst inside {[3'd4:3'd5]} ? 4'd7 :
                     hburst inside {[3'd6:3'd7]} ? 4'd15 : 4'd0;
    // Winner of an arbitration round; default master when nobody requests
    always_comb begin
        win = DEF;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 3; i >= 0; i--)
            if (req[i]) win = 2'(i);
`else
        for (int i = 4; i >= 1; i--)
            if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
`endif
    end
    // Ownership sequencing: decide hold vs re-arbitrate on each ready cycle
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        hmaster_d = hmaster_q;
        grant_d = grant_q;
        arb = 1'b0;
        if (hready) begin
            case (state_q)
                ARB: begin
                    if (lck[hmaster_q] & req[hmaster_q]) state_d = LOCKED;
                    else if (beat & nonseq & (blen_m1 != 4'd0)) begin
                        state_d = BURST;
                        cnt_d = blen_m1;
                    end else arb = 1'b1;
                end
                BURST: begin
                    if (beat & seq) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = ARB;
                            arb = 1'b1;
                        end
                    end else if (nonseq | idle) begin
                        state_d = ARB;
                        cnt_d = 4'd0;
                        arb = 1'b1;
                    end
                end
                default: begin
                    if (!lck[hmaster_q]) begin
                        state_d = ARB;
                        arb = 1'b1;
                    end
                end
            endcase
        end
        if (arb) begin
            hmaster_d = win;
            grant_d = NUM_MASTERS'(1) << win;
            ptr_d = |req ? win : ptr_q;
        end
        hmastlock_d = state_d == LOCKED;
    end
    // Registered state and outputs with synchronous reset to the default master
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ARB;
            cnt_q <= 4'd0;
            ptr_q <= DEF;
            hmaster_q <= DEF;
            grant_q <= NUM_MASTERS'(1) << DEF;
            hmastlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            hmaster_q <= hmaster_d;
            grant_q <= grant_d;
            hmastlock_q <= hmastlock_d;
        end
    end
    assign {grant4, grant3, grant2, grant1} = grant_q;
    assign hmaster = hmaster_q;
    assign hmastlock = hmastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed stimulus against an ownership model of the arbiter
module tb_ahb_bus_arbiter;
    localparam int DEF = 1;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;
    logic hclk = 1'b0, hreset = 1'b1, hready = 1'b1;
    logic [4:1] req = '0, lck = '0;
    logic [1:0] htrans = IDLE;
    logic [2:0] hburst = 3'b000;
    logic grant1, grant2, grant3, grant4, hmastlock;
    logic [1:0] hmaster;
    int vectors = 0, errors = 0;
    int m_owner = DEF, m_ptr = DEF, m_beats = 0;
    bit m_lock = 1'b0, live = 1'b0;

    always #5 hclk = ~hclk;

    ahb_bus_arbiter #(.DEFAULT_MASTER(DEF), .NUM_MASTERS(4)) dut (
        .hclk(hclk), .hreset(hreset),
        .hbusreq1(req[1]), .hbusreq2(req[2]), .hbusreq3(req[3]), .hbusreq4(req[4]),
        .hlock1(lck[1]), .hlock2(lck[2]), .hlock3(lck[3]), .hlock4(lck[4]),
        .hready(hready), .htrans(htrans), .hburst(hburst),
        .grant1(grant1), .grant2(grant2), .grant3(grant3), .grant4(grant4),
        .hmaster(hmaster), .hmastlock(hmastlock)
    );

    function automatic int burst_beats(logic [2:0] b);
        return b < 3'd2 ? 1 : b < 3'd4 ? 4 : b < 3'd6 ? 8 : 16;
    endfunction

    function automatic int pick();
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 1; k <= 4; k++) if (req[k]) return k;
`else
        for (int k = 0; k < 4; k++) if (req[(m_ptr + k) % 4 + 1]) return (m_ptr + k) % 4 + 1;
`endif
        return DEF;
    endfunction

    // Model: who owns the bus, whether it is locked, and how many burst beats remain
    always @(posedge hclk) begin
        bit rearb;
        rearb = 1'b0;
        if (hreset) begin
            live = 1'b1;
            m_owner = DEF;
            m_ptr = DEF;
            m_beats = 0;
            m_lock = 1'b0;
        end else if (hready) begin
            if (m_lock) begin
                if (!lck[m_owner]) begin
                    m_lock = 1'b0;
                    rearb = 1'b1;
                end
            end else if (m_beats > 0) begin
                if (htrans == SEQ) begin
                    m_beats = m_beats - 1;
                    rearb = m_beats == 0;
                end else if (htrans == NS || htrans == IDLE) begin
                    m_beats = 0;
                    rearb = 1'b1;
                end
            end else if (lck[m_owner] && req[m_owner]) m_lock = 1'b1;
            else if (htrans == NS && burst_beats(hburst) > 1) m_beats = burst_beats(hburst) - 1;
            else rearb = 1'b1;
            if (rearb) begin
                m_owner = pick();
                if (req != 4'b0) m_ptr = m_owner;
            end
        end
    end

    // Every cycle after reset, outputs must match the model
    always @(negedge hclk) begin
        logic [3:0] eg;
        if (live) begin
            eg = 4'b0001 << (m_owner - 1);
            vectors++;
            if ({grant4, grant3, grant2, grant1} !== eg || hmaster !== 2'(m_owner - 1) || hmastlock !== m_lock) begin
                errors++;
                $display("FAIL model t=%0t grant=%b hmaster=%0d hmastlock=%b expected grant=%b hmaster=%0d hmastlock=%b",
                         $time, {grant4, grant3, grant2, grant1}, hmaster, hmastlock, eg, m_owner - 1, m_lock);
            end
        end
    end

    task automatic drive(logic [4:1] r, logic [4:1] l, logic rdy, logic [1:0] t, logic [2:0] b);
        req = r;
        lck = l;
        hready = rdy;
        htrans = t;
        hburst = b;
        @(posedge hclk);
        #2;
    endtask

    task automatic chk(string nm, int own, logic lk);
        logic [3:0] eg;
        eg = 4'b0001 << (own - 1);
        vectors++;
        if ({grant4, grant3, grant2, grant1} !== eg || hmaster !== 2'(own - 1) || hmastlock !== lk) begin
            errors++;
            $display("FAIL %s grant=%b hmaster=%0d hmastlock=%b expected grant=%b hmaster=%0d hmastlock=%b",
                     nm, {grant4, grant3, grant2, grant1}, hmaster, hmastlock, eg, own - 1, lk);
        end
    endtask

    initial begin
        int rot[5];
        rot = '{2, 3, 4, 1, 2};
        drive(4'h0, 4'h0, 1, IDLE, 3'b000);
        drive(4'h0, 4'h0, 1, IDLE, 3'b000);
        chk("reset", 1, 0);
        hreset = 1'b0;
        repeat (5) begin
            drive(4'h0, 4'h0, 1, IDLE, 3'b000);
            chk("idle_default", 1, 0);
        end
`ifndef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 5; i++) begin
            drive(4'hF, 4'h0, 1, NS, 3'b000);
            chk("rotate", rot[i], 0);
        end
        drive(4'b0110, 4'h0, 1, NS, 3'b011);
        chk("incr4_start", 2, 0);
        drive(4'b0110, 4'h0, 1, SEQ, 3'b011);
        chk("incr4_beat2", 2, 0);
        drive(4'b0110, 4'h0, 0, SEQ, 3'b011);
        chk("incr4_stall", 2, 0);
        drive(4'b0110, 4'h0, 0, SEQ, 3'b011);
        chk("incr4_stall", 2, 0);
        drive(4'b0110, 4'h0, 1, SEQ, 3'b011);
        chk("incr4_beat3", 2, 0);
        drive(4'b0110, 4'h0, 1, SEQ, 3'b011);
        chk("incr4_end", 3, 0);
        drive(4'hF, 4'b0100, 1, NS, 3'b000);
        chk("lock_enter", 3, 1);
        drive(4'hF, 4'b0100, 1, NS, 3'b000);
        chk("lock_hold", 3, 1);
        drive(4'hF, 4'b0100, 0, NS, 3'b000);
        chk("lock_stall", 3, 1);
        drive(4'b1011, 4'b0100, 1, NS, 3'b000);
        chk("lock_noreq", 3, 1);
        drive(4'hF, 4'b0100, 1, NS, 3'b000);
        chk("lock_hold", 3, 1);
        drive(4'hF, 4'b0100, 1, NS, 3'b000);
        chk("lock_hold", 3, 1);
        drive(4'hF, 4'h0, 0, NS, 3'b000);
        chk("unlock_stall", 3, 1);
        drive(4'hF, 4'h0, 1, NS, 3'b000);
        chk("lock_exit", 4, 0);
        drive(4'b1000, 4'h0, 1, NS, 3'b101);
        chk("incr8_start", 4, 0);
        drive(4'b1000, 4'h0, 1, SEQ, 3'b101);
        drive(4'b1000, 4'h0, 1, SEQ, 3'b101);
        chk("incr8_mid", 4, 0);
        hreset = 1'b1;
        drive(4'hF, 4'h0, 1, SEQ, 3'b101);
        chk("reset_mid_burst", 1, 0);
        hreset = 1'b0;
        drive(4'b1000, 4'h0, 1, IDLE, 3'b000);
        chk("post_reset_arb", 4, 0);
        drive(4'b1001, 4'h0, 1, NS, 3'b010);
        chk("wrap4_start", 4, 0);
        drive(4'b1001, 4'h0, 1, BUSY, 3'b010);
        chk("busy_hold", 4, 0);
        drive(4'b1001, 4'h0, 1, SEQ, 3'b010);
        chk("wrap4_beat", 4, 0);
        drive(4'b1001, 4'h0, 1, IDLE, 3'b000);
        chk("early_term", 1, 0);
        drive(4'b0011, 4'b0001, 1, NS, 3'b011);
        chk("lock_over_burst", 1, 1);
        drive(4'b0011, 4'h0, 1, SEQ, 3'b011);
        chk("lock_drop", 2, 0);
        drive(4'b0011, 4'h0, 1, NS, 3'b001);
        chk("incr_single", 1, 0);
`else
        repeat (6) begin
            drive(4'b1010, 4'h0, 1, NS, 3'b000);
            chk("fixed_prio", 2, 0);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
